// File: rtl/symcount_pkg.sv
// Shared phase encodings, widths and helpers for the symbol-counting game controller.
package symcount_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LVL_W  = 4;
    localparam int unsigned LIFE_W = 2;

    // Phase codes are also decoded by the display mux.
    localparam logic [2:0] PHASE_IDLE    = 3'd0;
    localparam logic [2:0] PHASE_SHOW    = 3'd1;
    localparam logic [2:0] PHASE_COUNT   = 3'd2;
    localparam logic [2:0] PHASE_POST    = 3'd3;
    localparam logic [2:0] PHASE_RESOLVE = 3'd4;
    localparam logic [2:0] PHASE_WIN     = 3'd5;
    localparam logic [2:0] PHASE_OVER    = 3'd6;

    typedef enum logic [2:0] {
        StIdle    = PHASE_IDLE,
        StShow    = PHASE_SHOW,
        StCount   = PHASE_COUNT,
        StPost    = PHASE_POST,
        StResolve = PHASE_RESOLVE,
        StWin     = PHASE_WIN,
        StOver    = PHASE_OVER
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/symcount_sec_timer.sv
// Loadable seconds down-counter stepped by the 1 Hz tick; shared by all timed phases.
module symcount_sec_timer
    import symcount_pkg::*;
(
    input  logic             Clk100M,
    input  logic             Rst,
    input  logic             Clk1Hz,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic [CNT_W-1:0] secondsLeft,
    output logic             expire
);

    logic [CNT_W-1:0] secs_q, secs_d;

    always_comb begin
        secs_d = secs_q;
        if (load) begin
            secs_d = loadVal;
        end else if (en && Clk1Hz && (secs_q != '0)) begin
            secs_d = secs_q - 1'b1;
        end
    end

    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            secs_q <= '0;
        end else begin
            secs_q <= secs_d;
        end
    end

    assign secondsLeft = secs_q;
    // Combinational so the sequencer can load the next phase on the expiring tick itself.
    assign expire      = en && Clk1Hz && (secs_q == CNT_W'(1));

endmodule

// File: rtl/symcount_level_sequencer.sv
// Level sequencer for the symbol-counting game: SHOW -> COUNT -> POST -> RESOLVE per level.
// Optional POST watchdog enabled by defining POST_TIMEOUT_EN.
module symcount_level_sequencer
    import symcount_pkg::*;
#(
    parameter int unsigned SHOW_SECS         = 10,
    parameter int unsigned COUNT_SECS        = 5,
    parameter int unsigned MAX_LEVEL         = 9,
    parameter int unsigned START_LIVES       = 3,
    parameter int unsigned POST_TIMEOUT_SECS = 8
) (
    input  logic              Clk100M,
    input  logic              Rst,
    input  logic              Clk1Hz,
    input  logic              startBtn,
    input  logic              countBtn,
    input  logic [CNT_W-1:0]  magicSymbolCount,
    input  logic              levelComplete,
    output logic              showSig,
    output logic              countEn,
    output logic              postSig,
    output logic [CNT_W-1:0]  playerCount,
    output logic [LVL_W-1:0]  level,
    output logic [LIFE_W-1:0] lives,
    output logic [CNT_W-1:0]  secondsLeft,
    output logic [2:0]        phase,
    output logic              gameOver,
    output logic              gameWon
);

`ifdef POST_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0]  ShowLoad  = CNT_W'(SHOW_SECS);
    localparam logic [CNT_W-1:0]  CountLoad = CNT_W'(COUNT_SECS);
    localparam logic [CNT_W-1:0]  PostLoad  = TimeoutEn ? CNT_W'(POST_TIMEOUT_SECS) : '0;
    localparam logic [LVL_W-1:0]  LastLevel = LVL_W'(MAX_LEVEL);
    localparam logic [LIFE_W-1:0] InitLives = LIFE_W'(START_LIVES);

    state_e              state_q, state_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [LIFE_W-1:0]   lives_q, lives_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    magic_q, magic_d;
    logic                show_q, show_d;
    logic                post_q, post_d;
    logic                timeout_q, timeout_d;

    logic                tmr_en, tmr_load, tmr_expire;
    logic [CNT_W-1:0]    tmr_val;

    assign tmr_en = (state_q == StShow) || (state_q == StCount) || (state_q == StPost);

    symcount_sec_timer u_timer (
        .Clk100M     (Clk100M),
        .Rst         (Rst),
        .Clk1Hz      (Clk1Hz),
        .en          (tmr_en),
        .load        (tmr_load),
        .loadVal     (tmr_val),
        .secondsLeft (secondsLeft),
        .expire      (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        lives_d   = lives_q;
        count_d   = count_q;
        magic_d   = magic_q;
        timeout_d = timeout_q;
        show_d    = 1'b0;
        post_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        unique case (state_q)
            StIdle, StWin, StOver: begin
                if (state_q == StIdle) begin
                    level_d = LVL_W'(1);
                    lives_d = InitLives;
                    count_d = '0;
                end
                if (startBtn) begin
                    level_d  = LVL_W'(1);
                    lives_d  = InitLives;
                    count_d  = '0;
                    state_d  = StShow;
                    show_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = ShowLoad;
                end
            end
            StShow: begin
                if (tmr_expire) begin
                    state_d  = StCount;
                    tmr_load = 1'b1;
                    tmr_val  = CountLoad;
                end
            end
            StCount: begin
                if (countBtn) begin
                    count_d = sat_inc(count_q);
                end
                if (tmr_expire) begin
                    state_d  = StPost;
                    post_d   = 1'b1;
                    magic_d  = magicSymbolCount;
                    tmr_load = 1'b1;
                    tmr_val  = PostLoad;
                end
            end
            StPost: begin
                // PostPeriod cannot finish in its own start cycle.
                if (levelComplete && !post_q) begin
                    state_d   = StResolve;
                    timeout_d = 1'b0;
                end else if (TimeoutEn && tmr_expire) begin
                    state_d   = StResolve;
                    timeout_d = 1'b1;
                end
            end
            StResolve: begin
                if ((count_q == magic_q) && !timeout_q) begin
                    if (level_q == LastLevel) begin
                        state_d = StWin;
                    end else begin
                        level_d  = level_q + 1'b1;
                        count_d  = '0;
                        state_d  = StShow;
                        show_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = ShowLoad;
                    end
                end else if (lives_q == LIFE_W'(1)) begin
                    lives_d = '0;
                    state_d = StOver;
                end else begin
                    lives_d  = lives_q - 1'b1;
                    count_d  = '0;
                    state_d  = StShow;
                    show_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = ShowLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            state_q   <= StIdle;
            level_q   <= LVL_W'(1);
            lives_q   <= InitLives;
            count_q   <= '0;
            magic_q   <= '0;
            show_q    <= 1'b0;
            post_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            count_q   <= count_d;
            magic_q   <= magic_d;
            show_q    <= show_d;
            post_q    <= post_d;
            timeout_q <= timeout_d;
        end
    end

    assign showSig     = show_q;
    assign postSig     = post_q;
    assign countEn     = (state_q == StCount);
    assign playerCount = count_q;
    assign level       = level_q;
    assign lives       = lives_q;
    assign phase       = state_q;
    assign gameOver    = (state_q == StOver);
    assign gameWon     = (state_q == StWin);

endmodule

// File: tb/tb_symcount_level_sequencer.sv
// Directed bench for symcount_level_sequencer: per-cycle vector table plus multi-level sequences.
// Honours POST_TIMEOUT_EN when the design is built with it.
module tb_symcount_level_sequencer;

    logic       Clk100M = 1'b0;
    logic       Rst = 1'b1;
    logic       Clk1Hz = 1'b0;
    logic       startBtn = 1'b0;
    logic       countBtn = 1'b0;
    logic [7:0] magicSymbolCount = 8'd0;
    logic       levelComplete = 1'b0;
    logic       showSig, countEn, postSig, gameOver, gameWon;
    logic [7:0] playerCount, secondsLeft;
    logic [3:0] level;
    logic [1:0] lives;
    logic [2:0] phase;

`ifdef POST_TIMEOUT_EN
    localparam int PostSecs = 8;
`else
    localparam int PostSecs = 0;
`endif

    symcount_level_sequencer #(
        .SHOW_SECS         (2),
        .COUNT_SECS        (2),
        .MAX_LEVEL         (2),
        .START_LIVES       (2),
        .POST_TIMEOUT_SECS (8)
    ) dut (
        .Clk100M          (Clk100M),
        .Rst              (Rst),
        .Clk1Hz           (Clk1Hz),
        .startBtn         (startBtn),
        .countBtn         (countBtn),
        .magicSymbolCount (magicSymbolCount),
        .levelComplete    (levelComplete),
        .showSig          (showSig),
        .countEn          (countEn),
        .postSig          (postSig),
        .playerCount      (playerCount),
        .level            (level),
        .lives            (lives),
        .secondsLeft      (secondsLeft),
        .phase            (phase),
        .gameOver         (gameOver),
        .gameWon          (gameWon)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct {
        int rst, start, tick, cnt, lc, magic;
        int ph, show, cen, post, pc, lvl, lv, secs, won;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   tick_per = 100;
    int   tick_cnt = 0;
    int   ticks = 0;
    int   last_tick = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // One clock with a free-running 1 Hz tick every tick_per cycles; outputs valid on return.
    task automatic step(input logic s, input logic c, input logic l);
        startBtn      = s;
        countBtn      = c;
        levelComplete = l;
        Clk1Hz        = (tick_cnt == tick_per - 1);
        last_tick     = Clk1Hz ? 1 : 0;
        if (Clk1Hz) ticks++;
        tick_cnt      = (tick_cnt == tick_per - 1) ? 0 : tick_cnt + 1;
        @(posedge Clk100M);
        #1;
        startBtn = 1'b0; countBtn = 1'b0; levelComplete = 1'b0; Clk1Hz = 1'b0;
    endtask

    task automatic wait_phase(input logic [2:0] tgt, input int budget, input string nm);
        int n = 0;
        while (phase != tgt && n < budget) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check(nm, 32'(phase), 32'(tgt));
    endtask

    // Count phase with `presses` back-to-back presses, then levelComplete lc_delay cycles
    // after postSig; returns with the DUT in RESOLVE.
    task automatic play_level(input int magic, input int presses, input int lc_delay);
        magicSymbolCount = 8'(magic);
        wait_phase(3'd2, 400, "reach_count");
        for (int i = 0; i < presses; i++) step(1'b0, 1'b1, 1'b0);
        wait_phase(3'd3, 400, "reach_post");
        check("post_pulse", 32'(postSig), 1);
        check("post_count", 32'(playerCount), 32'(presses));
        for (int i = 1; i < lc_delay; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("resolve_after_lc", 32'(phase), 4);
    endtask

    initial begin
        int n;
        //        rst st tk cn lc mg   ph sh ce po pc lv li secs     won
        tbl.push_back('{1, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2, 0,        0});
        tbl.push_back('{0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2, 0,        0});
        tbl.push_back('{0, 0, 0, 1, 0, 4,  0, 0, 0, 0, 0, 1, 2, 0,        0});
        tbl.push_back('{0, 1, 0, 0, 0, 4,  1, 1, 0, 0, 0, 1, 2, 2,        0});
        tbl.push_back('{0, 0, 0, 0, 0, 4,  1, 0, 0, 0, 0, 1, 2, 2,        0});
        tbl.push_back('{0, 1, 0, 0, 0, 4,  1, 0, 0, 0, 0, 1, 2, 2,        0});
        tbl.push_back('{0, 0, 1, 0, 0, 4,  1, 0, 0, 0, 0, 1, 2, 1,        0});
        tbl.push_back('{0, 0, 0, 1, 0, 4,  1, 0, 0, 0, 0, 1, 2, 1,        0});
        tbl.push_back('{0, 0, 1, 0, 0, 4,  2, 0, 1, 0, 0, 1, 2, 2,        0});
        tbl.push_back('{0, 0, 0, 1, 0, 4,  2, 0, 1, 0, 1, 1, 2, 2,        0});
        tbl.push_back('{0, 0, 1, 1, 0, 4,  2, 0, 1, 0, 2, 1, 2, 1,        0});
        tbl.push_back('{0, 0, 0, 1, 0, 4,  2, 0, 1, 0, 3, 1, 2, 1,        0});
        tbl.push_back('{0, 0, 1, 1, 0, 4,  3, 0, 0, 1, 4, 1, 2, PostSecs, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4,  3, 0, 0, 0, 4, 1, 2, PostSecs, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 4,  3, 0, 0, 0, 4, 1, 2, PostSecs, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4,  4, 0, 0, 0, 4, 1, 2, PostSecs, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 2, 2, 2,        0});
        tbl.push_back('{0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 2, 2, 1,        0});
        tbl.push_back('{0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 0, 2, 2, 2,        0});
        tbl.push_back('{0, 0, 0, 1, 0, 1,  2, 0, 1, 0, 1, 2, 2, 2,        0});
        tbl.push_back('{0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 1, 2, 2, 1,        0});
        tbl.push_back('{0, 0, 1, 0, 0, 1,  3, 0, 0, 1, 1, 2, 2, PostSecs, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,  3, 0, 0, 0, 1, 2, 2, PostSecs, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1,  4, 0, 0, 0, 1, 2, 2, PostSecs, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1,  5, 0, 0, 0, 1, 2, 2, PostSecs, 1});
        tbl.push_back('{0, 0, 0, 1, 0, 1,  5, 0, 0, 0, 1, 2, 2, PostSecs, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 1,  5, 0, 0, 0, 1, 2, 2, PostSecs, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 1, 2, 2,        0});

        foreach (tbl[i]) begin
            Rst              = (tbl[i].rst != 0);
            startBtn         = (tbl[i].start != 0);
            Clk1Hz           = (tbl[i].tick != 0);
            countBtn         = (tbl[i].cnt != 0);
            levelComplete    = (tbl[i].lc != 0);
            magicSymbolCount = 8'(tbl[i].magic);
            @(posedge Clk100M);
            #1;
            if (phase !== 3'(tbl[i].ph) || showSig !== (tbl[i].show != 0) ||
                countEn !== (tbl[i].cen != 0) || postSig !== (tbl[i].post != 0) ||
                playerCount !== 8'(tbl[i].pc) || level !== 4'(tbl[i].lvl) ||
                lives !== 2'(tbl[i].lv) || secondsLeft !== 8'(tbl[i].secs) ||
                gameWon !== (tbl[i].won != 0)) begin
                failures++;
                $display("FAIL vec%0d got ph=%0d sh=%b ce=%b po=%b pc=%0d lv=%0d li=%0d s=%0d w=%b want ph=%0d sh=%0d ce=%0d po=%0d pc=%0d lv=%0d li=%0d s=%0d w=%0d",
                         i, phase, showSig, countEn, postSig, playerCount, level, lives,
                         secondsLeft, gameWon, tbl[i].ph, tbl[i].show, tbl[i].cen,
                         tbl[i].post, tbl[i].pc, tbl[i].lvl, tbl[i].lv, tbl[i].secs,
                         tbl[i].won);
            end
            checks++;
        end
        Rst = 1'b0; startBtn = 1'b0; Clk1Hz = 1'b0; countBtn = 1'b0; levelComplete = 1'b0;

        // Full game win with 1 Hz ticks every 100 clocks.
        Rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        Rst = 1'b0;
        tick_cnt = 0;
        ticks = 0;
        step(1'b1, 1'b0, 1'b0);
        check("start_show", 32'(showSig), 1);
        check("start_lvl", 32'(level), 1);
        check("start_lives", 32'(lives), 2);
        wait_phase(3'd2, 400, "a_reach_count");
        check("counten_on_2nd_tick", 32'(ticks * 2 + last_tick), 5);
        play_level(27, 27, 50);
        step(1'b0, 1'b0, 1'b0);
        check("pass_show", 32'(showSig), 1);
        check("pass_lvl", 32'(level), 2);
        check("pass_pc", 32'(playerCount), 0);
        play_level(5, 5, 10);
        step(1'b0, 1'b0, 1'b0);
        check("win_flag", 32'(gameWon), 1);
        check("win_phase", 32'(phase), 5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        check("win_pc_hold", 32'(playerCount), 5);
        step(1'b1, 1'b0, 1'b0);
        check("restart_show", 32'(showSig), 1);
        check("restart_lvl", 32'(level), 1);

        // Two failed levels end the game.
        play_level(27, 26, 5);
        step(1'b0, 1'b0, 1'b0);
        check("fail1_lives", 32'(lives), 1);
        check("fail1_lvl", 32'(level), 1);
        check("fail1_phase", 32'(phase), 1);
        play_level(27, 26, 5);
        step(1'b0, 1'b0, 1'b0);
        check("over_flag", 32'(gameOver), 1);
        check("over_lives", 32'(lives), 0);
        step(1'b1, 1'b0, 1'b0);
        check("over_restart_lvl", 32'(level), 1);
        check("over_restart_lives", 32'(lives), 2);
        check("over_restart_show", 32'(showSig), 1);

        // Saturation: press every COUNT cycle including the final tick.
        tick_per = 200;
        tick_cnt = 0;
        wait_phase(3'd2, 800, "sat_reach_count");
        n = 0;
        while (phase == 3'd2 && n < 1000) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        check("sat_phase", 32'(phase), 3);
        check("sat_pc", 32'(playerCount), 32'((n > 255) ? 255 : n));

        // Reset in the middle of POST.
        step(1'b0, 1'b0, 1'b0);
        Rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        Rst = 1'b0;
        check("rst_phase", 32'(phase), 0);
        check("rst_outs", 32'({showSig, countEn, postSig, gameOver, gameWon}), 0);
        check("rst_pc", 32'(playerCount), 0);
        check("rst_lvl_lives", 32'({level, lives}), 32'({4'd1, 2'd2}));
        check("rst_secs", 32'(secondsLeft), 0);

        // POST with no levelComplete: watchdog fail, or indefinite wait.
        tick_per = 100;
        tick_cnt = 0;
        magicSymbolCount = 8'd0;
        step(1'b1, 1'b0, 1'b0);
        wait_phase(3'd3, 600, "to_reach_post");
`ifdef POST_TIMEOUT_EN
        wait_phase(3'd4, 1000, "to_resolve");
        step(1'b0, 1'b0, 1'b0);
        check("to_fail_lives", 32'(lives), 1);
        check("to_fail_lvl", 32'(level), 1);
`else
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 1'b0);
        check("post_wait_phase", 32'(phase), 3);
        check("post_wait_secs", 32'(secondsLeft), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
